// File: rtl/led_fader_if.sv
// Pattern/intensity inputs and PWM LED drive of the led_fader afterglow stage.
interface led_fader_if #(
    parameter int unsigned NLED  = 8,
    parameter int unsigned MXPWM = 8
);
    logic [NLED-1:0]  pattern_in;
    logic [MXPWM-1:0] brightness;
    logic [1:0]       decay_rate;
    logic [NLED-1:0]  led_out;

    modport master (output pattern_in, output brightness, output decay_rate, input led_out);
    modport slave  (input pattern_in, input brightness, input decay_rate, output led_out);
endinterface

// File: rtl/led_fader.sv
// Per-channel PWM afterglow: lit pattern bits load an intensity that decays stepwise.
// Optional macro LED_FADER_GAMMA_EN squares the intensity before the PWM compare.
module led_fader #(
    parameter int unsigned NLED    = 8,
    parameter int unsigned MXPWM   = 8,
    parameter int unsigned MXDECAY = 16
) (
    input  logic      clock,
    input  logic      reset,
    led_fader_if.slave bus
);
    localparam int unsigned SQW = 2 * MXPWM;

    logic [MXPWM-1:0]   pwm_cnt;
    logic [MXDECAY-1:0] decay_pre;
    logic               decay_tick_c;
    logic [MXPWM-1:0]   step_c;
    logic [MXPWM-1:0]   level [NLED];
    logic [MXPWM-1:0]   eff_c [NLED];
    logic [NLED-1:0]    led_q;

    assign decay_tick_c = (decay_pre == {MXDECAY{1'b1}});
    assign step_c       = MXPWM'(1) << bus.decay_rate;
    assign bus.led_out  = led_q;

    // Shared PWM counter and decay prescaler keep all channels phase-aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt   <= '0;
            decay_pre <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + MXPWM'(1);
            decay_pre <= decay_pre + MXDECAY'(1);
        end
    end

    // Load beats decay; decay saturates at zero instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NLED; i++) level[i] <= '0;
        end else begin
            for (int i = 0; i < NLED; i++) begin
                if (bus.pattern_in[i]) begin
                    level[i] <= bus.brightness;
                end else if (decay_tick_c) begin
                    level[i] <= (level[i] >= step_c) ? level[i] - step_c : '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NLED; g++) begin : g_eff
`ifdef LED_FADER_GAMMA_EN
        assign eff_c[g] = MXPWM'((SQW'(level[g]) * SQW'(level[g])) >> MXPWM);
`else
        assign eff_c[g] = level[g];
`endif
    end

    // Strict compare: full-scale intensity still leaves one off slot per period.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            for (int i = 0; i < NLED; i++) led_q[i] <= (eff_c[i] > pwm_cnt);
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// Randomized + directed bench for led_fader with a cycle-count based reference model.
module tb_led_fader;
    localparam int unsigned NLED    = 8;
    localparam int unsigned MXPWM   = 8;
    localparam int unsigned MXDECAY = 4;
    localparam int          PERIOD  = 1 << MXPWM;
    localparam int          TICKP   = 1 << MXDECAY;

    logic clock = 1'b0;
    logic reset = 1'b0;
    led_fader_if #(.NLED(NLED), .MXPWM(MXPWM)) bus ();

    led_fader #(.NLED(NLED), .MXPWM(MXPWM), .MXDECAY(MXDECAY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since reset drives both PWM phase and decay ticks.
    int       cyc = 0;
    int       lvl [NLED];
    logic [NLED-1:0] exp_led = '0;
    bit       model_ok = 1'b0;

    function automatic int eff_of(input int l);
`ifdef LED_FADER_GAMMA_EN
        return (l * l) >> MXPWM;
`else
        return l;
`endif
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            cyc = 0;
            for (int i = 0; i < NLED; i++) lvl[i] = 0;
            exp_led = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            int step;
            bit tick;
            step = 1 << bus.decay_rate;
            tick = ((cyc % TICKP) == TICKP - 1);
            for (int i = 0; i < NLED; i++) begin
                exp_led[i] = (eff_of(lvl[i]) > (cyc % PERIOD));
                if (bus.pattern_in[i]) lvl[i] = int'(bus.brightness);
                else if (tick) lvl[i] = (lvl[i] >= step) ? lvl[i] - step : 0;
            end
            cyc++;
        end
    end

    always @(negedge clock) begin
        if (model_ok) check("led_model", int'(bus.led_out), int'(exp_led));
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic duty(input string tag, input int exp_high);
        int hi = 0;
        int other = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clock);
            hi += int'(bus.led_out[0]);
            other |= int'(bus.led_out[NLED-1:1]);
        end
        check(tag, hi, exp_high);
        check({tag, "_others"}, other, 0);
    endtask

    initial begin
        bus.pattern_in = '0;
        bus.brightness = '0;
        bus.decay_rate = '0;

        // Reset holds everything dark even with every channel requested.
        @(negedge clock);
        bus.pattern_in = 8'hFF;
        bus.brightness = 8'hFF;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("rst_hold", int'(bus.led_out), 0);
        end
        reset = 1'b0;
        bus.pattern_in = '0;
        @(negedge clock);
        check("rst_release", int'(bus.led_out), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("rst_after", int'(bus.led_out), 0);
        end

        // Duty cycle at three brightness points; wait out the load latency first.
        bus.pattern_in = 8'h01;
        bus.brightness = 8'h80;
        step_n(2);
`ifdef LED_FADER_GAMMA_EN
        duty("duty_80", 64);
        bus.brightness = 8'h10; step_n(2);
        duty("duty_10", 1);
`else
        duty("duty_80", 128);
        bus.brightness = 8'hFF; step_n(2);
        duty("duty_ff", 255);
        bus.brightness = 8'h00; step_n(2);
        duty("duty_00", 0);
`endif

        // Linear fade from 16 with step 1 runs out after 16 ticks.
        bus.brightness = 8'h10;
        bus.decay_rate = 2'd0;
        step_n(3);
        bus.pattern_in = '0;
        step_n(17 * TICKP);
        duty("fade_done", 0);

        // Step 8 from 5 saturates to zero on the first tick.
        bus.pattern_in = 8'h01;
        bus.brightness = 8'h05;
        bus.decay_rate = 2'd3;
        step_n(3);
        bus.pattern_in = '0;
        step_n(TICKP + 2);
        duty("sat_zero", 0);

        // Held channel ignores ticks and tracks brightness.
        bus.pattern_in = 8'h04;
        bus.brightness = 8'h40;
        bus.decay_rate = 2'd0;
        step_n(3 * TICKP);
        bus.brightness = 8'h20;
        step_n(2 * TICKP);

        // Cylon trail with step 4; explicit two-edge latency on a fresh channel.
        bus.brightness = 8'hFF;
        bus.decay_rate = 2'd2;
        for (int p = 0; p < 3; p++) begin
            bus.pattern_in = NLED'(1) << p;
            step_n(40);
        end
        bus.pattern_in = 8'h80;
        @(negedge clock);
        check("lat_edge1", int'(bus.led_out[7]), 0);
        @(negedge clock);
        check("lat_edge2", int'(bus.led_out[7]), int'((cyc - 1) % PERIOD != PERIOD - 1));
        step_n(60);

        // Random traffic with occasional mid-fade resets.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) bus.pattern_in = NLED'(1) << $urandom_range(0, NLED - 1);
            else if (r < 11) bus.pattern_in = '0;
            else if (r < 13) bus.pattern_in = NLED'($urandom);
            if (r >= 95) bus.brightness = MXPWM'($urandom);
            if (r == 50) bus.decay_rate = 2'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clock);
            if (reset) check("rnd_rst", int'(bus.led_out), 0);
        end
        reset = 1'b0;
        step_n(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
